// File: rtl/bitcnt_pkg.sv
// Shared types for the bit-count issue stage: function codes, data width and the
// queued request entry.
package bitcnt_pkg;

   localparam int DATA_W    = 64;
   localparam int MAX_TAG_W = 16;

   typedef enum logic [2:0] {
      CLZ_64 = 3'd0,
      CLZ_32 = 3'd1,
      CTZ_64 = 3'd2,
      CTZ_32 = 3'd3,
      CNT_64 = 3'd4,
      CNT_32 = 3'd5
   } func_e;

   // func is kept as a raw code so that the unused codes 6/7 survive the queue
   typedef struct packed {
      logic [DATA_W-1:0]    data;
      logic [2:0]           func;
      logic [MAX_TAG_W-1:0] tag;
   } req_t;

   function automatic logic func_is_legal(input logic [2:0] f);
      return f <= 3'(CNT_32);
   endfunction

endpackage

// File: rtl/bitcnt_fifo.sv
// Synchronous request FIFO with registered full flag and occupancy count.
// DEPTH must be a power of two so that the pointers wrap naturally.
module bitcnt_fifo
   import bitcnt_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   i_push,
   input  req_t                   i_entry,
   input  logic                   i_pop,
   output req_t                   o_head,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int PTR_W = $clog2(DEPTH);

   req_t             r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic [PTR_W:0]   w_count_nxt;
   logic             r_full;
   logic             w_push;
   logic             w_pop;

   assign w_push = i_push & ~r_full;
   assign w_pop  = i_pop & (r_count != '0);

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + (PTR_W+1)'(1);
         2'b01:   w_count_nxt = r_count - (PTR_W+1)'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == (PTR_W+1)'(DEPTH));
      end
   end

   // NOTE: storage has no reset; the occupancy count alone decides which slots are valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_entry;
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_full  = r_full;
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/bitcnt_issue.sv
// Issue stage for a combinational bit-count unit: request FIFO, head drive, result register.
// Define BITCNT_ILLEGAL_CHECK_EN to flag func codes 6/7 with dout_err and a zero result.
module bitcnt_issue
   import bitcnt_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              din_valid,
   output logic              din_ready,
   input  logic [DATA_W-1:0] din_data,
   input  logic [2:0]        din_func,
   input  logic [TAG_W-1:0]  din_tag,
   output logic [DATA_W-1:0] cnt_data,
   output logic [2:0]        cnt_func,
   input  logic [DATA_W-1:0] cnt_result,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic [DATA_W-1:0] dout_data,
   output logic [TAG_W-1:0]  dout_tag,
   output logic              dout_err,
   output logic              busy
);

   req_t                   w_entry;
   req_t                   w_head;
   logic                   w_full;
   logic                   w_empty;
   logic [$clog2(DEPTH):0] w_count;
   logic                   w_push;
   logic                   w_advance;
   logic                   w_illegal;
   logic [DATA_W-1:0]      w_result;
   logic                   w_unused_tag;

   logic                   r_armed;
   logic                   r_dout_valid;
   logic [DATA_W-1:0]      r_dout_data;
   logic [TAG_W-1:0]       r_dout_tag;
   logic                   r_dout_err;

   // Keeps din_ready low until the first edge after reset release
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_armed <= 1'b0;
      else         r_armed <= 1'b1;
   end

   assign din_ready = r_armed & ~w_full;
   assign w_push    = din_valid & din_ready;
   assign w_entry   = '{data: din_data, func: din_func, tag: MAX_TAG_W'(din_tag)};
   assign w_advance = ~w_empty & (~r_dout_valid | dout_ready);

   bitcnt_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .i_push  (w_push),
      .i_entry (w_entry),
      .i_pop   (w_advance),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign cnt_data     = w_empty ? '0 : w_head.data;
   assign cnt_func     = w_empty ? '0 : w_head.func;
   assign w_unused_tag = ^w_head.tag;

`ifdef BITCNT_ILLEGAL_CHECK_EN
   assign w_illegal = ~func_is_legal(w_head.func);
   assign w_result  = w_illegal ? '0 : cnt_result;
`else
   assign w_illegal = 1'b0;
   assign w_result  = cnt_result;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_dout_valid <= 1'b0;
         r_dout_data  <= '0;
         r_dout_tag   <= '0;
         r_dout_err   <= 1'b0;
      end else if (w_advance) begin
         r_dout_valid <= 1'b1;
         r_dout_data  <= w_result;
         r_dout_tag   <= w_head.tag[TAG_W-1:0];
         r_dout_err   <= w_illegal;
      end else if (dout_ready) begin
         r_dout_valid <= 1'b0;
      end
   end

   assign dout_valid = r_dout_valid;
   assign dout_data  = r_dout_data;
   assign dout_tag   = r_dout_tag;
   assign dout_err   = r_dout_err;
   assign busy       = (w_count != '0) | r_dout_valid;

endmodule

// File: tb/tb_bitcnt_issue.sv
// Scoreboard bench for bitcnt_issue: directed corner cases plus randomized traffic
// against a loop-based counting reference.
module tb_bitcnt_issue;

   localparam int DEPTH = 4;
   localparam int TAG_W = 4;

   typedef struct packed {
      logic [63:0]      data;
      logic [TAG_W-1:0] tag;
      logic             err;
   } exp_t;

   logic             clk = 1'b0;
   logic             resetn;
   logic             din_valid;
   logic             din_ready;
   logic [63:0]      din_data;
   logic [2:0]       din_func;
   logic [TAG_W-1:0] din_tag;
   logic [63:0]      cnt_data;
   logic [2:0]       cnt_func;
   logic [63:0]      cnt_result;
   logic             dout_valid;
   logic             dout_ready;
   logic [63:0]      dout_data;
   logic [TAG_W-1:0] dout_tag;
   logic             dout_err;
   logic             busy;

   int   n_checks = 0;
   int   n_err    = 0;
   exp_t exp_q[$];

   bitcnt_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .din_data   (din_data),
      .din_func   (din_func),
      .din_tag    (din_tag),
      .cnt_data   (cnt_data),
      .cnt_func   (cnt_func),
      .cnt_result (cnt_result),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout_data  (dout_data),
      .dout_tag   (dout_tag),
      .dout_err   (dout_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Counting reference: plain bit loops; unused codes return the inverted operand
   function automatic logic [63:0] ref_count(input logic [63:0] d, input logic [2:0] f);
      int n;
      int w;
      w = (f == 3'd1 || f == 3'd3 || f == 3'd5) ? 32 : 64;
      n = 0;
      case (f)
         3'd0, 3'd1: begin
            n = w;
            for (int i = 0; i < w; i++) if (d[i]) n = w - 1 - i;
         end
         3'd2, 3'd3: begin
            n = w;
            for (int i = w - 1; i >= 0; i--) if (d[i]) n = i;
         end
         3'd4, 3'd5: begin
            for (int i = 0; i < w; i++) n += int'(d[i]);
         end
         default: return ~d;
      endcase
      return 64'(n);
   endfunction

   always_comb cnt_result = ref_count(cnt_data, cnt_func);

   function automatic exp_t expect_of(input logic [63:0] d, input logic [2:0] f,
                                      input logic [TAG_W-1:0] t);
      exp_t e;
      e.data = ref_count(d, f);
      e.tag  = t;
      e.err  = 1'b0;
`ifdef BITCNT_ILLEGAL_CHECK_EN
      if (f >= 3'd6) begin
         e.data = '0;
         e.err  = 1'b1;
      end
`endif
      return e;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: in-order result comparison and hold-stability under backpressure
   logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_rst = 1'b0, prev_err = 1'b0;
   logic [63:0] prev_data = '0;
   logic [TAG_W-1:0] prev_tag = '0;

   always @(negedge clk) begin
      exp_t e;
      if (resetn && prev_rst && prev_valid && !prev_ready) begin
         n_checks++;
         if (!dout_valid || dout_data !== prev_data || dout_tag !== prev_tag || dout_err !== prev_err) begin
            n_err++;
            $display("FAIL hold_stable: got v=%0b d=%0h t=%0h e=%0b expected v=1 d=%0h t=%0h e=%0b",
                     dout_valid, dout_data, dout_tag, dout_err, prev_data, prev_tag, prev_err);
         end
      end
      if (resetn && dout_valid && dout_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_result: got d=%0h t=%0h, expected no result", dout_data, dout_tag);
         end else begin
            e = exp_q.pop_front();
            check("sb_data", dout_data, e.data);
            check("sb_tag", 64'(dout_tag), 64'(e.tag));
            check("sb_err", 64'(dout_err), 64'(e.err));
         end
      end
      prev_valid = dout_valid;
      prev_ready = dout_ready;
      prev_rst   = resetn;
      prev_data  = dout_data;
      prev_tag   = dout_tag;
      prev_err   = dout_err;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [63:0] d, input logic [2:0] f, input logic [TAG_W-1:0] t);
      logic ok;
      ok = 1'b0;
      din_valid = 1'b1;
      din_data  = d;
      din_func  = f;
      din_tag   = t;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         ok = din_ready;
         tick();
      end
      if (ok) begin
         exp_q.push_back(expect_of(d, f, t));
      end else begin
         n_checks++;
         n_err++;
         $display("FAIL push_timeout: got din_ready=0 for 200 cycles, expected 1");
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      dout_ready = 1'b1;
      while ((exp_q.size() != 0 || dout_valid) && n < 100) begin
         tick();
         n++;
      end
      check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
   endtask

   logic             drv_done;
   logic [63:0]      tag_data [5];
   int               seen;

   initial begin
      resetn     = 1'b0;
      din_valid  = 1'b0;
      din_data   = '0;
      din_func   = '0;
      din_tag    = '0;
      dout_ready = 1'b1;
      repeat (3) tick();

      // Reset state
      check("rst_din_ready", 64'(din_ready), 64'd0);
      check("rst_dout_valid", 64'(dout_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_dout_data", dout_data, 64'd0);
      check("rst_dout_tag", 64'(dout_tag), 64'd0);
      check("rst_dout_err", 64'(dout_err), 64'd0);
      check("rst_cnt_data", cnt_data, 64'd0);
      check("rst_cnt_func", 64'(cnt_func), 64'd0);
      resetn = 1'b1;
      #1;
      check("ready_before_first_edge", 64'(din_ready), 64'd0);
      tick();
      check("ready_after_first_edge", 64'(din_ready), 64'd1);

      // CLZ_64 of 1: head visible after push edge, result one edge later
      push(64'h1, 3'd0, 4'd1);
      din_valid = 1'b0;
      check("lat_not_yet_valid", 64'(dout_valid), 64'd0);
      check("lat_head_data", cnt_data, 64'h1);
      check("lat_busy", 64'(busy), 64'd1);
      tick();
      check("lat_valid", 64'(dout_valid), 64'd1);
      check("lat_clz64", dout_data, 64'd63);
      tick();

      // CTZ_32 of 0 then CNT_64 of all-ones, back to back
      push(64'h0, 3'd3, 4'd5);
      push('1, 3'd4, 4'd6);
      din_valid = 1'b0;
      check("b2b_first_data", dout_data, 64'd32);
      check("b2b_first_tag", 64'(dout_tag), 64'd5);
      tick();
      check("b2b_second_valid", 64'(dout_valid), 64'd1);
      check("b2b_second_data", dout_data, 64'd64);
      check("b2b_second_tag", 64'(dout_tag), 64'd6);
      tick();
      check("b2b_drained", 64'(dout_valid), 64'd0);

      // Backpressure: five requests fill the output register and the FIFO
      dout_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tag_data[i] = 64'hF0F0_0000_0000_0000 >> (i * 4);
         push(tag_data[i], 3'd4, TAG_W'(i + 2));
      end
      din_valid = 1'b0;
      check("full_din_ready", 64'(din_ready), 64'd0);
      check("full_dout_valid", 64'(dout_valid), 64'd1);
      check("full_head_tag", 64'(dout_tag), 64'd2);
      repeat (3) tick();
      check("full_hold_data", dout_data, ref_count(tag_data[0], 3'd4));
      dout_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("rel_valid", 64'(dout_valid), 64'd1);
         check("rel_tag", 64'(dout_tag), 64'(i + 2));
         check("rel_data", dout_data, ref_count(tag_data[i], 3'd4));
         if (i == 0) check("rel_ready_pop_cycle", 64'(din_ready), 64'd0);
         if (i == 1) check("rel_ready_after_pop", 64'(din_ready), 64'd1);
         tick();
      end
      check("rel_done", 64'(dout_valid), 64'd0);

      // Unused function code 6
      push(64'hFF, 3'd6, 4'd3);
      din_valid = 1'b0;
      tick();
      check("illegal_tag", 64'(dout_tag), 64'd3);
`ifdef BITCNT_ILLEGAL_CHECK_EN
      check("illegal_err", 64'(dout_err), 64'd1);
      check("illegal_data", dout_data, 64'd0);
`else
      check("illegal_err", 64'(dout_err), 64'd0);
      check("illegal_data", dout_data, ~64'hFF);
`endif
      tick();

      // Randomized traffic with random backpressure
      drv_done = 1'b0;
      fork
         begin
            logic [63:0] d;
            for (int n = 0; n < 80; n++) begin
               din_valid = 1'b0;
               repeat ($urandom_range(0, 2)) tick();
               case ($urandom_range(0, 3))
                  0:       d = '0;
                  1:       d = '1;
                  2:       d = 64'h1 << $urandom_range(0, 63);
                  default: d = {$urandom, $urandom};
               endcase
               push(d, 3'($urandom_range(0, 7)), TAG_W'(n));
            end
            din_valid = 1'b0;
            drv_done = 1'b1;
         end
         begin
            while (!drv_done) begin
               dout_ready = ($urandom_range(0, 3) != 0);
               tick();
            end
         end
      join
      drain();
      tick();

      // Reset mid-operation discards queued and pending results
      dout_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(64'(i + 7), 3'd5, TAG_W'(i + 8));
      din_valid = 1'b0;
      check("pre_rst_valid", 64'(dout_valid), 64'd1);
      check("pre_rst_busy", 64'(busy), 64'd1);
      resetn = 1'b0;
      exp_q.delete();
      #1;
      check("mid_rst_valid", 64'(dout_valid), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_ready", 64'(din_ready), 64'd0);
      check("mid_rst_data", dout_data, 64'd0);
      repeat (2) tick();
      resetn = 1'b1;
      dout_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (dout_valid || busy) seen++;
         tick();
      end
      check("post_rst_no_output", 64'(seen), 64'd0);
      check("post_rst_ready", 64'(din_ready), 64'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
